// File: rtl/echo_delay_ctrl_pkg.sv
// Shared types and constants for the echo delay line and the audio processor.
package echo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // Converter offsets the processor and this block must agree on
   localparam logic [9:0] ADC_OFFSET = 10'h181;
   localparam logic [9:0] DAC_OFFSET = 10'h200;

   localparam int unsigned ADDR_W_DEFAULT = 13;

endpackage

// File: rtl/echo_delay_ctrl_edge_pulse.sv
// One-cycle pulse on each rising edge of a slow synchronous strobe.
module edge_pulse (
   input  logic sysclk,
   input  logic rst_n,
   input  logic sig,
   output logic pulse
);

   logic sig_q;

   always_ff @(posedge sysclk) begin
      if (!rst_n) sig_q <= 1'b0;
      else        sig_q <= sig;
   end

   assign pulse = sig & ~sig_q;

endmodule

// File: rtl/echo_delay_ctrl.sv
// Echo delay line sequencer: circular-buffer addressing with an explicit fill/run FSM.
module echo_delay_ctrl
   import echo_pkg::*;
#(
   parameter int unsigned ADDR_W        = ADDR_W_DEFAULT,
   parameter int unsigned DELAY_DEFAULT = 4800
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic              data_valid,
   input  logic [ADDR_W-1:0] delay_cfg,
   input  logic              cfg_load,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              echo_valid,
   output logic              echo_en,
   output logic              filling
);

   state_t            state, state_d;
   logic              tick;
   logic [ADDR_W-1:0] delay_q, delay_d;
   logic [ADDR_W-1:0] fill_cnt, fill_d;
   logic [ADDR_W-1:0] wp, wp_d;
   logic [ADDR_W-1:0] cfg_val;
   logic              wr_en_d, rd_en_d;
   logic [ADDR_W-1:0] wr_addr_d, rd_addr_d;

   edge_pulse u_edge (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .sig    (data_valid),
      .pulse  (tick)
   );

   assign cfg_val = (delay_cfg == '0) ? ADDR_W'(1) : delay_cfg;

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         delay_q    <= ADDR_W'(DELAY_DEFAULT);
         fill_cnt   <= '0;
         wp         <= '0;
         wr_en      <= 1'b0;
         rd_en      <= 1'b0;
         wr_addr    <= '0;
         rd_addr    <= '0;
         echo_valid <= 1'b0;
      end else begin
         state      <= state_d;
         delay_q    <= delay_d;
         fill_cnt   <= fill_d;
         wp         <= wp_d;
         wr_en      <= wr_en_d;
         rd_en      <= rd_en_d;
         wr_addr    <= wr_addr_d;
         rd_addr    <= rd_addr_d;
         echo_valid <= rd_en;
      end
   end

   always_comb begin
      state_d   = state;
      delay_d   = delay_q;
      fill_d    = fill_cnt;
      wp_d      = wp;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      wr_addr_d = wr_addr;
      rd_addr_d = rd_addr;

      if (tick) begin
         case (state)
            ST_IDLE, ST_FILL: begin
               wr_en_d   = 1'b1;
               wr_addr_d = wp;
               wp_d      = wp + ADDR_W'(1);
               if (fill_cnt == delay_q - ADDR_W'(1)) begin
                  state_d = ST_RUN;
                  fill_d  = '0;
               end else begin
                  state_d = ST_FILL;
                  fill_d  = fill_cnt + ADDR_W'(1);
               end
            end
            ST_RUN: begin
               wr_en_d   = 1'b1;
               rd_en_d   = 1'b1;
               wr_addr_d = wp;
               rd_addr_d = wp - delay_q;
               wp_d      = wp + ADDR_W'(1);
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // A coincident tick has already been handled with the old delay; the
      // restart overrides only the state it left behind.
      if (cfg_load) begin
         delay_d = cfg_val;
         if ((cfg_val != delay_q) && (state_d != ST_IDLE)) begin
            state_d = ST_FILL;
            fill_d  = '0;
         end
      end
   end

   assign echo_en = (state == ST_RUN);
   assign filling = (state == ST_FILL);

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Randomized bench for echo_delay_ctrl against a history-count reference model.
module tb_echo_delay_ctrl;

   localparam int unsigned AW    = 4;
   localparam int          DEPTH = 16;

   logic          sysclk = 1'b0;
   logic          rst_n = 1'b0;
   logic          data_valid = 1'b0;
   logic [AW-1:0] delay_cfg = '0;
   logic          cfg_load = 1'b0;
   logic          wr_en, rd_en, echo_valid, echo_en, filling;
   logic [AW-1:0] wr_addr, rd_addr;

   int checks = 0;
   int failures = 0;

   // Reference model: how many samples the line holds since the last (re)start
   int  m_wp;
   int  m_delay;
   int  m_held;
   bit  m_started;

   echo_delay_ctrl #(.ADDR_W(AW), .DELAY_DEFAULT(4)) dut (
      .sysclk     (sysclk),
      .rst_n      (rst_n),
      .data_valid (data_valid),
      .delay_cfg  (delay_cfg),
      .cfg_load   (cfg_load),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .echo_valid (echo_valid),
      .echo_en    (echo_en),
      .filling    (filling)
   );

   always #5 sysclk = ~sysclk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int clamp(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic bit exp_run();
      return m_started && (m_held >= m_delay);
   endfunction

   function automatic bit exp_fill();
      return m_started && (m_held < m_delay);
   endfunction

   task automatic model_cfg(input int v);
      int nd;
      nd = clamp(v);
      if (m_started && nd != m_delay) m_held = 0;
      m_delay = nd;
   endtask

   task automatic do_reset();
      @(negedge sysclk);
      rst_n = 1'b0;
      data_valid = 1'b0;
      cfg_load = 1'b0;
      @(negedge sysclk);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_echo_valid", echo_valid, 0);
      check("rst_echo_en", echo_en, 0);
      check("rst_filling", filling, 0);
      rst_n = 1'b1;
      m_wp = 0; m_delay = 4; m_held = 0; m_started = 0;
   endtask

   task automatic idle_low(input int n);
      for (int i = 0; i < n; i++) @(negedge sysclk);
   endtask

   // One ADC strobe; optionally a cfg_load in the same cycle as the tick
   task automatic do_tick(input bit load, input int cfg);
      int  e_wa, e_ra;
      bit  e_rd;
      check("pre_echo_en", echo_en, exp_run());
      check("pre_filling", filling, exp_fill());
      e_wa = m_wp;
      e_rd = exp_run();
      e_ra = (m_wp + DEPTH - m_delay) % DEPTH;
      data_valid = 1'b1;
      cfg_load = load;
      delay_cfg = AW'(cfg);
      m_wp = (m_wp + 1) % DEPTH;
      m_started = 1;
      if (m_held < m_delay) m_held++;
      if (load) model_cfg(cfg);
      @(negedge sysclk);
      cfg_load = 1'b0;
      check("wr_en", wr_en, 1);
      check("wr_addr", wr_addr, e_wa);
      check("rd_en", rd_en, e_rd);
      if (e_rd) check("rd_addr", rd_addr, e_ra);
      check("echo_en", echo_en, exp_run());
      check("filling", filling, exp_fill());
      @(negedge sysclk);
      check("wr_en_pulse", wr_en, 0);
      check("echo_valid", echo_valid, e_rd);
      idle_low($urandom_range(0, 3));
      data_valid = 1'b0;
      idle_low($urandom_range(1, 3));
   endtask

   task automatic do_cfg(input int v);
      cfg_load = 1'b1;
      delay_cfg = AW'(v);
      model_cfg(v);
      @(negedge sysclk);
      cfg_load = 1'b0;
      check("cfg_echo_en", echo_en, exp_run());
      check("cfg_filling", filling, exp_fill());
      @(negedge sysclk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pulses;
      do_reset();

      // fill with default delay, then run through several wraps
      for (int i = 0; i < 20; i++) do_tick(1'b0, 0);

      // shrink delay on a tick, refill, run
      do_tick(1'b1, 2);
      for (int i = 0; i < 4; i++) do_tick(1'b0, 0);

      // zero clamps to one; unchanged value keeps running
      do_cfg(0);
      for (int i = 0; i < 3; i++) do_tick(1'b0, 0);
      do_cfg(1);
      check("same_cfg_echo_en", echo_en, 1);
      do_tick(1'b0, 0);

      // reset in the cycle of a strobe after two fill writes
      do_reset();
      do_tick(1'b0, 0);
      do_tick(1'b0, 0);
      rst_n = 1'b0;
      data_valid = 1'b1;
      @(negedge sysclk);
      check("midfill_wr_en", wr_en, 0);
      check("midfill_wr_addr", wr_addr, 0);
      check("midfill_filling", filling, 0);
      data_valid = 1'b0;
      rst_n = 1'b1;
      m_wp = 0; m_delay = 4; m_held = 0; m_started = 0;
      @(negedge sysclk);
      do_tick(1'b0, 0);

      // long strobe yields one write
      pulses = 0;
      data_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge sysclk);
         if (wr_en) pulses++;
      end
      data_valid = 1'b0;
      m_wp = (m_wp + 1) % DEPTH;
      if (m_held < m_delay) m_held++;
      check("held_strobe_pulses", pulses, 1);
      idle_low(2);

      // randomized traffic with occasional reconfiguration
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 9))
            0:       do_tick(1'b1, $urandom_range(0, 15));
            1:       do_cfg($urandom_range(0, 15));
            2:       do_cfg(m_delay);
            default: do_tick(1'b0, 0);
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
